pipe_skid_buffer: RTL

//   Valid/ready pipeline stage register with a one-entry skid slot. It sits between two

---
 rtl/pipe_pkg.sv | 13 +
 rtl/flopenr.sv | 23 ++
 rtl/pipe_skid_buffer.sv | 111 +++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the valid/ready skid buffer stage.
// No logic; state encoding only.
// Not applicable (no handshake in a package).
package pipe_pkg;

  // Occupancy of the stage: nothing held, main slot only, main plus skid slot.
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_t;

endpackage : pipe_pkg

// File: rtl/flopenr.sv
// Enabled data register with asynchronous active-high clear.
// One cycle: d is captured on the rising edge when en is high.
// No handshake; the owner decides when to load through en.
module flopenr #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Load on enable, clear immediately on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule : flopenr

// File: rtl/pipe_skid_buffer.sv
// Two-entry valid/ready pipeline stage (main slot plus skid slot).
// One cycle: a word accepted at edge N is presented on out_data after edge N.
// in_ready is registered from the next state, so it never follows out_ready combinationally.
module pipe_skid_buffer
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  skid_state_t      state_q, state_d;
  logic             out_valid_q;
  logic             in_ready_q;
  logic             accept;
  logic             emit;
  logic             main_en;
  logic             skid_en;
  logic             main_from_skid;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;

  assign accept = in_valid & in_ready_q;
  assign emit   = out_valid_q & out_ready;

  // Next-state and data-register enables; flush overrides every transfer.
  always_comb begin
    state_d        = state_q;
    main_en        = 1'b0;
    skid_en        = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_d = SKID_EMPTY;
    end else begin
      unique case (state_q)
        SKID_EMPTY: begin
          if (accept) begin
            main_en = 1'b1;
            state_d = SKID_ONE;
          end
        end
        SKID_ONE: begin
          if (accept && emit) begin
            main_en = 1'b1;
          end else if (accept) begin
            // Downstream stalled: park the new word behind the one on the output.
            skid_en = 1'b1;
            state_d = SKID_FULL;
          end else if (emit) begin
            state_d = SKID_EMPTY;
          end
        end
        SKID_FULL: begin
          if (emit) begin
            main_en        = 1'b1;
            main_from_skid = 1'b1;
            state_d        = SKID_ONE;
          end
        end
        default: begin
          state_d = SKID_EMPTY;
        end
      endcase
    end
  end

  assign main_d = main_from_skid ? skid_q : in_data;

  // State, output valid and input ready all registered from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= SKID_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      out_valid_q <= (state_d != SKID_EMPTY);
      in_ready_q  <= (state_d != SKID_FULL);
    end
  end

  flopenr #(.WIDTH(WIDTH)) u_main_reg (
    .clk   (clk),
    .reset (reset),
    .en    (main_en),
    .d     (main_d),
    .q     (main_q)
  );

  flopenr #(.WIDTH(WIDTH)) u_skid_reg (
    .clk   (clk),
    .reset (reset),
    .en    (skid_en),
    .d     (in_data),
    .q     (skid_q)
  );

  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;
  assign out_data  = main_q;

endmodule : pipe_skid_buffer
